ts_packet_checker: RTL and testbench

TS_PACKET_CHECKER -- requirements
Module: ts_packet_checker

---
 rtl/ts_pkg.sv | 17 +
 rtl/ts_cc_table.sv | 85 ++++++++
 rtl/ts_packet_checker.sv | 180 ++++++++++++++++++
 tb/tb_ts_packet_checker.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ts_pkg.sv
// Shared transport-stream constants and the packet-parser state encoding.
package ts_pkg;

    localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;
    localparam int          TS_PKT_LEN   = 188;
    localparam logic [12:0] TS_NULL_PID  = 13'h1FFF;
    localparam logic [7:0]  TS_LAST_IDX  = 8'(TS_PKT_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR1,
        ST_HDR2,
        ST_HDR3,
        ST_PAYLOAD
    } ts_state_e;

endpackage

// File: rtl/ts_cc_table.sv
// PID slot table for continuity-counter tracking: lookup, duplicate allowance,
// first-free allocation and round-robin replacement when full.
module ts_cc_table
    import ts_pkg::*;
#(
    parameter int PID_SLOTS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lookup_i,
    input  logic [12:0] pid_i,
    input  logic [3:0]  cc_i,
    input  logic        has_payload_i,
    input  logic        tei_i,
    output logic        cc_err_o
);

    localparam int IW = $clog2(PID_SLOTS);

    logic [PID_SLOTS-1:0] valid_q;
    logic [PID_SLOTS-1:0] dup_q;
    logic [12:0]          pid_mem_q [PID_SLOTS];
    logic [3:0]           cc_mem_q  [PID_SLOTS];
    logic [IW-1:0]        victim_q;

    logic          active;
    logic          hit;
    logic          free_found;
    logic [IW-1:0] hit_idx;
    logic [IW-1:0] free_idx;
    logic [IW-1:0] tgt_idx;
    logic [3:0]    last_cc;
    logic [3:0]    exp_cc;
    logic          dup_ok;

    assign active = lookup_i && (pid_i != TS_NULL_PID);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        // Descending scan so the lowest matching/free index wins.
        for (int i = PID_SLOTS - 1; i >= 0; i--) begin
            if (valid_q[i] && pid_mem_q[i] == pid_i) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
        tgt_idx = hit ? hit_idx : (free_found ? free_idx : victim_q);
        last_cc = cc_mem_q[hit_idx];
        exp_cc  = has_payload_i ? last_cc + 4'd1 : last_cc;
        dup_ok  = has_payload_i && !tei_i && (cc_i == last_cc) && !dup_q[hit_idx];
    end

    assign cc_err_o = active && hit && !tei_i && !dup_ok && (cc_i != exp_cc);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= '0;
            dup_q    <= '0;
            victim_q <= '0;
        end else if (active) begin
            valid_q[tgt_idx] <= 1'b1;
            dup_q[tgt_idx]   <= hit && dup_ok;
            if (!hit && !free_found) begin
                victim_q <= victim_q + IW'(1);
            end
        end
    end

    // NOTE: slot contents are qualified by valid_q, so the storage itself needs no reset.
    always_ff @(posedge clk) begin
        if (active) begin
            pid_mem_q[tgt_idx] <= pid_i;
            cc_mem_q[tgt_idx]  <= cc_i;
        end
    end

endmodule

// File: rtl/ts_packet_checker.sv
// MPEG-TS packet parser/checker: header extraction, continuity and length checks.
// Statistics counters exist only when TS_CHECKER_STATS_EN is defined.
module ts_packet_checker
    import ts_pkg::*;
#(
    parameter int PID_SLOTS = 8,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           ts_byte,
    input  logic                 ts_valid,
    input  logic                 ts_sync,
    output logic                 hdr_valid,
    output logic [12:0]          pid,
    output logic [3:0]           cc,
    output logic [1:0]           afc,
    output logic                 tei,
    output logic                 pusi,
    output logic                 cc_err,
    output logic                 len_err,
    output logic [CNT_WIDTH-1:0] pkt_cnt,
    output logic [CNT_WIDTH-1:0] cc_err_cnt,
    output logic [CNT_WIDTH-1:0] len_err_cnt
);

    ts_state_e   state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic        tei_s_q, pusi_s_q;
    logic [4:0]  pid_hi_q;
    logic [7:0]  pid_lo_q;
    logic        hdr_valid_q, cc_err_q, len_err_q;
    logic [12:0] pid_q;
    logic [3:0]  cc_q;
    logic [1:0]  afc_q;
    logic        tei_q, pusi_q;

    logic sync_start;
    logic hdr_fire;
    logic len_fire;
    logic tbl_err;

    assign sync_start = ts_sync && (ts_byte == TS_SYNC_BYTE);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        hdr_fire = 1'b0;
        len_fire = 1'b0;
        if (ts_valid) begin
            if (state_q == ST_IDLE) begin
                if (sync_start) begin
                    state_d = ST_HDR1;
                    idx_d   = 8'd1;
                end
            end else if (ts_sync && idx_q != TS_LAST_IDX) begin
                // Early sync: drop the packet and re-qualify this byte as a start.
                len_fire = 1'b1;
                state_d  = sync_start ? ST_HDR1 : ST_IDLE;
                idx_d    = sync_start ? 8'd1 : 8'd0;
            end else begin
                idx_d = idx_q + 8'd1;
                case (state_q)
                    ST_HDR1: state_d = ST_HDR2;
                    ST_HDR2: state_d = ST_HDR3;
                    ST_HDR3: begin
                        state_d  = ST_PAYLOAD;
                        hdr_fire = 1'b1;
                    end
                    ST_PAYLOAD: begin
                        if (idx_q == TS_LAST_IDX) begin
                            state_d = ST_IDLE;
                            idx_d   = 8'd0;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    ts_cc_table #(
        .PID_SLOTS (PID_SLOTS)
    ) u_cc_table (
        .clk           (clk),
        .rst           (rst),
        .lookup_i      (hdr_fire),
        .pid_i         ({pid_hi_q, pid_lo_q}),
        .cc_i          (ts_byte[3:0]),
        .has_payload_i (ts_byte[4]),
        .tei_i         (tei_s_q),
        .cc_err_o      (tbl_err)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            tei_s_q     <= 1'b0;
            pusi_s_q    <= 1'b0;
            pid_hi_q    <= '0;
            pid_lo_q    <= '0;
            hdr_valid_q <= 1'b0;
            cc_err_q    <= 1'b0;
            len_err_q   <= 1'b0;
            pid_q       <= '0;
            cc_q        <= '0;
            afc_q       <= '0;
            tei_q       <= 1'b0;
            pusi_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            hdr_valid_q <= hdr_fire;
            cc_err_q    <= hdr_fire && tbl_err;
            len_err_q   <= len_fire;
            if (ts_valid && !len_fire && state_q == ST_HDR1) begin
                tei_s_q  <= ts_byte[7];
                pusi_s_q <= ts_byte[6];
                pid_hi_q <= ts_byte[4:0];
            end
            if (ts_valid && !len_fire && state_q == ST_HDR2) begin
                pid_lo_q <= ts_byte;
            end
            // Visible header fields change only together with hdr_valid.
            if (hdr_fire) begin
                pid_q  <= {pid_hi_q, pid_lo_q};
                cc_q   <= ts_byte[3:0];
                afc_q  <= ts_byte[5:4];
                tei_q  <= tei_s_q;
                pusi_q <= pusi_s_q;
            end
        end
    end

    assign hdr_valid = hdr_valid_q;
    assign cc_err    = cc_err_q;
    assign len_err   = len_err_q;
    assign pid       = pid_q;
    assign cc        = cc_q;
    assign afc       = afc_q;
    assign tei       = tei_q;
    assign pusi      = pusi_q;

`ifdef TS_CHECKER_STATS_EN
    logic                 pkt_done;
    logic [CNT_WIDTH-1:0] pkt_cnt_q, cc_err_cnt_q, len_err_cnt_q;

    assign pkt_done = ts_valid && (state_q == ST_PAYLOAD) && (idx_q == TS_LAST_IDX);

    // Counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_q     <= '0;
            cc_err_cnt_q  <= '0;
            len_err_cnt_q <= '0;
        end else begin
            if (pkt_done && pkt_cnt_q != '1) begin
                pkt_cnt_q <= pkt_cnt_q + CNT_WIDTH'(1);
            end
            if (hdr_fire && tbl_err && cc_err_cnt_q != '1) begin
                cc_err_cnt_q <= cc_err_cnt_q + CNT_WIDTH'(1);
            end
            if (len_fire && len_err_cnt_q != '1) begin
                len_err_cnt_q <= len_err_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign pkt_cnt     = pkt_cnt_q;
    assign cc_err_cnt  = cc_err_cnt_q;
    assign len_err_cnt = len_err_cnt_q;
`else
    assign pkt_cnt     = '0;
    assign cc_err_cnt  = '0;
    assign len_err_cnt = '0;
`endif

endmodule

// File: tb/tb_ts_packet_checker.sv
// Directed self-checking bench for ts_packet_checker; expected counter values
// follow TS_CHECKER_STATS_EN (all zero when the statistics are compiled out).
module tb_ts_packet_checker;

    localparam int PID_SLOTS = 8;
    localparam int CNT_WIDTH = 32;
`ifdef TS_CHECKER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic [7:0]           ts_byte;
    logic                 ts_valid;
    logic                 ts_sync;
    logic                 hdr_valid;
    logic [12:0]          pid;
    logic [3:0]           cc;
    logic [1:0]           afc;
    logic                 tei;
    logic                 pusi;
    logic                 cc_err;
    logic                 len_err;
    logic [CNT_WIDTH-1:0] pkt_cnt;
    logic [CNT_WIDTH-1:0] cc_err_cnt;
    logic [CNT_WIDTH-1:0] len_err_cnt;

    int n_cmp    = 0;
    int n_fail   = 0;
    int n_hdr    = 0;
    int n_ccerr  = 0;
    int n_lenerr = 0;
    bit last_err = 1'b0;
    bit gap_en   = 1'b0;

    ts_packet_checker #(
        .PID_SLOTS (PID_SLOTS),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ts_byte     (ts_byte),
        .ts_valid    (ts_valid),
        .ts_sync     (ts_sync),
        .hdr_valid   (hdr_valid),
        .pid         (pid),
        .cc          (cc),
        .afc         (afc),
        .tei         (tei),
        .pusi        (pusi),
        .cc_err      (cc_err),
        .len_err     (len_err),
        .pkt_cnt     (pkt_cnt),
        .cc_err_cnt  (cc_err_cnt),
        .len_err_cnt (len_err_cnt)
    );

    always #5 clk = ~clk;

    // Pulse monitor on the falling edge; each one-cycle pulse is seen exactly once.
    always @(negedge clk) begin
        if (hdr_valid) begin
            n_hdr++;
            last_err = cc_err;
        end
        if (cc_err)  n_ccerr++;
        if (len_err) n_lenerr++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] stat(input int n);
        return STATS ? 32'(n) : 32'd0;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic s);
        if (gap_en) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                ts_valid = 1'b0;
                ts_byte  = 8'($urandom);
                ts_sync  = 1'($urandom);
                @(posedge clk);
                #1;
            end
        end
        @(negedge clk);
        ts_byte  = b;
        ts_sync  = s;
        ts_valid = 1'b1;
        @(posedge clk);
        #1;
        ts_valid = 1'b0;
        ts_sync  = 1'b0;
    endtask

    task automatic send_pkt(input logic [12:0] p, input logic [3:0] c, input logic [1:0] a,
                            input logic t, input int first, input int last);
        logic [7:0] b;
        for (int i = first; i <= last; i++) begin
            case (i)
                0:       b = 8'h47;
                1:       b = {t, 1'b0, 1'b0, p[12:8]};
                2:       b = p[7:0];
                3:       b = {2'b00, a, c};
                default: b = 8'($urandom);
            endcase
            send_byte(b, i == 0);
            if (i == 3) check("hdr_valid_after_idx3", 32'(hdr_valid), 32'd1);
            if (i == 4) check("hdr_valid_single_cycle", 32'(hdr_valid), 32'd0);
        end
    endtask

    task automatic full_pkt(input string tag, input logic [12:0] p, input logic [3:0] c,
                            input logic [1:0] a, input logic t, input logic exp_err);
        send_pkt(p, c, a, t, 0, 187);
        check({tag, "_cc_err"}, 32'(last_err), 32'(exp_err));
        check({tag, "_pid"}, 32'(pid), 32'(p));
        check({tag, "_cc"}, 32'(cc), 32'(c));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        ts_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hdr_valid", 32'(hdr_valid), 32'd0);
        check("rst_cc_err", 32'(cc_err), 32'd0);
        check("rst_len_err", 32'(len_err), 32'd0);
        check("rst_pid", 32'(pid), 32'd0);
        check("rst_cc", 32'(cc), 32'd0);
        check("rst_afc", 32'(afc), 32'd0);
        check("rst_tei_pusi", 32'({tei, pusi}), 32'd0);
        check("rst_pkt_cnt", pkt_cnt, 32'd0);
        check("rst_cc_err_cnt", cc_err_cnt, 32'd0);
        check("rst_len_err_cnt", len_err_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int base_cc;
        int base_len;
        rst      = 1'b1;
        ts_valid = 1'b0;
        ts_sync  = 1'b0;
        ts_byte  = 8'h00;

        do_reset();

        // Three clean packets on PID 0x100.
        for (int i = 0; i < 3; i++) full_pkt("clean", 13'h100, 4'(i), 2'b01, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("clean_hdr_count", 32'(n_hdr), 32'd3);
        check("clean_cc_err_count", 32'(n_ccerr), 32'd0);
        check("clean_pkt_cnt", pkt_cnt, stat(3));
        check("clean_afc", 32'(afc), 32'd1);

        // Skip: 3 -> 5 is an error, 6 follows 5 cleanly.
        full_pkt("skip_cc3", 13'h100, 4'd3, 2'b01, 1'b0, 1'b0);
        full_pkt("skip_cc5", 13'h100, 4'd5, 2'b01, 1'b0, 1'b1);
        full_pkt("skip_cc6", 13'h100, 4'd6, 2'b01, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("skip_cc_err_count", 32'(n_ccerr), 32'd1);
        check("skip_cc_err_cnt", cc_err_cnt, stat(1));

        // Duplicates: 6 -> 4 errors, one repeat of 4 allowed, a second repeat errors.
        full_pkt("dup_first", 13'h100, 4'd4, 2'b01, 1'b0, 1'b1);
        full_pkt("dup_second", 13'h100, 4'd4, 2'b01, 1'b0, 1'b0);
        full_pkt("dup_third", 13'h100, 4'd4, 2'b01, 1'b0, 1'b1);
        full_pkt("afc_no_payload", 13'h100, 4'd4, 2'b10, 1'b0, 1'b0);
        check("afc_no_payload_afc", 32'(afc), 32'd2);

        // TEI suppresses the check; the stored cc still advances.
        full_pkt("tei_set", 13'h100, 4'd9, 2'b01, 1'b1, 1'b0);
        check("tei_out", 32'(tei), 32'd1);
        full_pkt("tei_after", 13'h100, 4'd10, 2'b01, 1'b0, 1'b0);
        check("tei_cleared", 32'(tei), 32'd0);

        // Short packet: sync at index 100.
        base_len = n_lenerr;
        send_pkt(13'h200, 4'd0, 2'b01, 1'b0, 0, 99);
        send_byte(8'h47, 1'b1);
        check("short_len_err_pulse", 32'(len_err), 32'd1);
        send_pkt(13'h200, 4'd1, 2'b01, 1'b0, 1, 187);
        check("short_new_cc_err", 32'(last_err), 32'd0);
        check("short_new_pid", 32'(pid), 32'h200);
        check("short_new_cc", 32'(cc), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("short_len_err_count", 32'(n_lenerr - base_len), 32'd1);
        check("short_len_err_cnt", len_err_cnt, stat(1));
        check("short_pkt_cnt", pkt_cnt, stat(13));
        check("total_cc_err_cnt", cc_err_cnt, stat(3));

        // Slot table pressure: nine PIDs in eight slots.
        do_reset();
        base_cc = n_ccerr;
        for (int i = 0; i < 9; i++) full_pkt("alloc", 13'(16 + i), 4'd0, 2'b01, 1'b0, 1'b0);
        full_pkt("evicted_pid_realloc", 13'h010, 4'd7, 2'b01, 1'b0, 1'b0);
        full_pkt("tracked_pid_skip", 13'h012, 4'd5, 2'b01, 1'b0, 1'b1);
        full_pkt("tracked_pid_ok", 13'h013, 4'd1, 2'b01, 1'b0, 1'b0);
        full_pkt("ninth_pid_tracked", 13'h018, 4'd1, 2'b01, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) full_pkt("null_pid", 13'h1FFF, 4'($urandom), 2'b01, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("slots_cc_err_count", 32'(n_ccerr - base_cc), 32'd1);
        check("slots_cc_err_cnt", cc_err_cnt, stat(1));
        check("slots_pkt_cnt", pkt_cnt, stat(18));

        // Gapped stimulus with a reset in the middle of a packet.
        gap_en   = 1'b1;
        base_len = n_lenerr;
        base_cc  = n_ccerr;
        send_pkt(13'h300, 4'd0, 2'b01, 1'b0, 0, 50);
        do_reset();
        full_pkt("gap_cc0", 13'h300, 4'd0, 2'b01, 1'b0, 1'b0);
        full_pkt("gap_cc1", 13'h300, 4'd1, 2'b01, 1'b0, 1'b0);
        full_pkt("gap_cc3", 13'h300, 4'd3, 2'b01, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("gap_no_len_err", 32'(n_lenerr - base_len), 32'd0);
        check("gap_cc_err_count", 32'(n_ccerr - base_cc), 32'd1);
        check("gap_pkt_cnt", pkt_cnt, stat(3));
        check("gap_cc_err_cnt", cc_err_cnt, stat(1));
        check("gap_len_err_cnt", len_err_cnt, stat(0));
        check("gap_idle_hdr_valid", 32'(hdr_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
